// File: rtl/regfile_rename_if.sv
// regfile_rename_if: commit, rename, flush and decoder read-port signals of the rename register file.
interface regfile_rename_if #(
  parameter int REG_CNT = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W = 3,
  parameter int RD_PORTS = 2
);
  localparam int RN_W = $clog2(REG_CNT);
  localparam int LOCK_W = ROB_W + 1;
  localparam int CNT_W = $clog2(REG_CNT) + 1;
  logic commit_we;
  logic [RN_W-1:0] commit_name;
  logic [DATA_W-1:0] commit_data;
  logic [ROB_W-1:0] commit_entry;
  logic rename_we;
  logic [RN_W-1:0] rename_name;
  logic [ROB_W-1:0] rename_entry;
  logic flush;
  logic [RD_PORTS-1:0] rd_re;
  logic [RD_PORTS*RN_W-1:0] rd_name;
  logic [RD_PORTS*LOCK_W-1:0] rd_lock;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [CNT_W-1:0] locked_cnt;
  modport master (
    output commit_we, commit_name, commit_data, commit_entry,
    output rename_we, rename_name, rename_entry, flush, rd_re, rd_name,
    input rd_lock, rd_data, locked_cnt
  );
  modport slave (
    input commit_we, commit_name, commit_data, commit_entry,
    input rename_we, rename_name, rename_entry, flush, rd_re, rd_name,
    output rd_lock, rd_data, locked_cnt
  );
endinterface

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register ROB rename locks, flush and locked count.
// Optional macro RF_BYPASS_EN forwards a same-cycle commit to the read ports.
module regfile_rename #(
  parameter int REG_CNT = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W = 3,
  parameter int RD_PORTS = 2
) (
  input logic clk,
  input logic rst,
  regfile_rename_if.slave bus
);
  localparam int RN_W = $clog2(REG_CNT);
  localparam int LOCK_W = ROB_W + 1;
  localparam int CNT_W = $clog2(REG_CNT) + 1;
  localparam logic [LOCK_W-1:0] NO_LOCK = {1'b1, {ROB_W{1'b0}}};
  logic [DATA_W-1:0] dat [REG_CNT];
  logic [LOCK_W-1:0] loc [REG_CNT];
  logic [LOCK_W-1:0] loc_nxt [REG_CNT];
  logic [CNT_W-1:0] cnt_nxt;
  logic [RN_W-1:0] nm [RD_PORTS];
  logic byp [RD_PORTS];
  logic [RD_PORTS*LOCK_W-1:0] rd_lock_v;
  logic [RD_PORTS*DATA_W-1:0] rd_data_v;
  // Priority: flush clears everything, rename beats a matching commit's unlock.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      loc_nxt[i] = loc[i];
      if (i == 0 || bus.flush)
        loc_nxt[i] = NO_LOCK;
      else if (bus.rename_we && bus.rename_name == RN_W'(i))
        loc_nxt[i] = {1'b0, bus.rename_entry};
      else if (bus.commit_we && bus.commit_name == RN_W'(i) && loc[i] == {1'b0, bus.commit_entry})
        loc_nxt[i] = NO_LOCK;
      cnt_nxt = cnt_nxt + CNT_W'(~loc_nxt[i][ROB_W]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        dat[i] <= '0;
        loc[i] <= NO_LOCK;
      end
      bus.locked_cnt <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++) loc[i] <= loc_nxt[i];
      if (bus.commit_we && bus.commit_name != '0) dat[bus.commit_name] <= bus.commit_data;
      bus.locked_cnt <= cnt_nxt;
    end
  end
  always_comb begin
    rd_lock_v = '0;
    rd_data_v = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      nm[k] = bus.rd_name[k*RN_W +: RN_W];
`ifdef RF_BYPASS_EN
      byp[k] = bus.commit_we && bus.commit_name == nm[k] && nm[k] != '0;
`else
      byp[k] = 1'b0;
`endif
      rd_lock_v[k*LOCK_W +: LOCK_W] = (!bus.rd_re[k] || nm[k] == '0) ? NO_LOCK :
        (byp[k] && loc[nm[k]] == {1'b0, bus.commit_entry}) ? NO_LOCK : loc[nm[k]];
      rd_data_v[k*DATA_W +: DATA_W] = (!bus.rd_re[k] || nm[k] == '0) ? '0 :
        byp[k] ? bus.commit_data : dat[nm[k]];
    end
  end
  assign bus.rd_lock = rd_lock_v;
  assign bus.rd_data = rd_data_v;
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: directed plus random stimulus against an owner/value array model of the rename register file.
module tb_regfile_rename;
  localparam int REGS = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int m_owner [REGS];
  logic [31:0] m_val [REGS];
  always #5 clk = ~clk;
  regfile_rename_if #(.REG_CNT(32), .DATA_W(32), .ROB_W(3), .RD_PORTS(2)) bus ();
  regfile_rename #(.REG_CNT(32), .DATA_W(32), .ROB_W(3), .RD_PORTS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] enc(int o);
    return (o < 0) ? 4'b1000 : {1'b0, 3'(o)};
  endfunction
  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < REGS; i++) if (m_owner[i] >= 0) c++;
    return c;
  endfunction
  task automatic model_edge();
    int cn, rn;
    cn = int'(bus.commit_name);
    rn = int'(bus.rename_name);
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        m_owner[i] = -1;
        m_val[i] = 0;
      end
      return;
    end
    if (bus.commit_we && cn != 0) begin
      m_val[cn] = bus.commit_data;
      if (m_owner[cn] == int'(bus.commit_entry) && !(bus.rename_we && rn == cn)) m_owner[cn] = -1;
    end
    if (bus.flush) for (int i = 0; i < REGS; i++) m_owner[i] = -1;
    else if (bus.rename_we && rn != 0) m_owner[rn] = int'(bus.rename_entry);
  endtask
  task automatic cycle(bit chk_rd);
    int n;
    logic [3:0] el;
    logic [31:0] ed;
    bit hit;
    #1;
    if (chk_rd) for (int k = 0; k < 2; k++) begin
      n = int'(bus.rd_name[k*5 +: 5]);
      hit = BYPASS && bus.commit_we && int'(bus.commit_name) == n && n != 0;
      if (!bus.rd_re[k] || n == 0) begin
        el = 4'b1000;
        ed = 0;
      end else begin
        el = (hit && m_owner[n] == int'(bus.commit_entry)) ? 4'b1000 : enc(m_owner[n]);
        ed = hit ? bus.commit_data : m_val[n];
      end
      check($sformatf("rd_lock%0d r%0d", k, n), 64'(bus.rd_lock[k*4 +: 4]), 64'(el));
      check($sformatf("rd_data%0d r%0d", k, n), 64'(bus.rd_data[k*32 +: 32]), 64'(ed));
    end
    @(posedge clk);
    model_edge();
    #1;
    check("locked_cnt", 64'(bus.locked_cnt), 64'(model_cnt()));
    @(negedge clk);
  endtask
  task automatic idle();
    bus.commit_we = 0;
    bus.rename_we = 0;
    bus.flush = 0;
  endtask
  task automatic set_rd(int n0, int n1);
    bus.rd_re = 2'b11;
    bus.rd_name = {5'(n1), 5'(n0)};
  endtask
  task automatic do_rename(int n, int e);
    bus.rename_we = 1;
    bus.rename_name = 5'(n);
    bus.rename_entry = 3'(e);
  endtask
  task automatic do_commit(int n, int e, logic [31:0] d);
    bus.commit_we = 1;
    bus.commit_name = 5'(n);
    bus.commit_entry = 3'(e);
    bus.commit_data = d;
  endtask
  initial begin
    int cn;
    for (int i = 0; i < REGS; i++) begin
      m_owner[i] = -1;
      m_val[i] = 0;
    end
    rst = 1;
    idle();
    bus.commit_name = 0; bus.commit_entry = 0; bus.commit_data = 0;
    bus.rename_name = 0; bus.rename_entry = 0;
    set_rd(5, 0);
    @(negedge clk);
    cycle(0);
    rst = 0;
    cycle(1);
    check("reset_cnt", 64'(bus.locked_cnt), 64'd0);
    do_rename(3, 2); cycle(1);
    idle(); set_rd(3, 0); #1;
    check("r3_locked", 64'(bus.rd_lock[3:0]), 64'h2);
    cycle(1);
    do_commit(3, 2, 32'hDEAD); cycle(1);
    idle(); #1;
    check("r3_commit_data", 64'(bus.rd_data[31:0]), 64'hDEAD);
    check("r3_commit_lock", 64'(bus.rd_lock[3:0]), 64'h8);
    cycle(1);
    do_rename(3, 2); cycle(1);
    do_rename(3, 5); cycle(1);
    idle(); do_commit(3, 2, 32'h11); cycle(1);
    idle(); #1;
    check("stale_lock", 64'(bus.rd_lock[3:0]), 64'h5);
    check("stale_data", 64'(bus.rd_data[31:0]), 64'h11);
    cycle(1);
    do_rename(7, 1); set_rd(7, 3); cycle(1);
    do_commit(7, 1, 32'h42); do_rename(7, 4); cycle(1);
    idle(); #1;
    check("r7_lock", 64'(bus.rd_lock[3:0]), 64'h4);
    check("r7_data", 64'(bus.rd_data[31:0]), 64'h42);
    cycle(1);
    do_rename(1, 0); cycle(1);
    do_rename(2, 6); cycle(1);
    do_rename(9, 7); cycle(1);
    idle(); set_rd(1, 9); cycle(1);
    bus.flush = 1; do_rename(4, 3); set_rd(2, 4); cycle(1);
    idle(); #1;
    check("flush_cnt", 64'(bus.locked_cnt), 64'd0);
    check("flush_r4", 64'(bus.rd_lock[7:4]), 64'h8);
    cycle(1);
    do_rename(6, 3); cycle(1);
    idle(); do_commit(8, 0, 32'h88); cycle(1);
    idle(); do_commit(6, 3, 32'h77); set_rd(6, 8); #1;
    check("byp_lock0", 64'(bus.rd_lock[3:0]), BYPASS ? 64'h8 : 64'h3);
    check("byp_data0", 64'(bus.rd_data[31:0]), BYPASS ? 64'h77 : 64'h0);
    check("byp_data1", 64'(bus.rd_data[63:32]), 64'h88);
    cycle(1);
    idle(); bus.rd_re = 2'b00; set_rd(6, 8); bus.rd_re = 2'b00; cycle(1);
    for (int t = 0; t < 500; t++) begin
      rst = ($urandom_range(99) == 0);
      cn = $urandom_range(REGS - 1);
      bus.commit_we = $urandom_range(1);
      bus.commit_name = 5'(cn);
      bus.commit_entry = (m_owner[cn] >= 0 && $urandom_range(2) != 0) ? 3'(m_owner[cn]) : 3'($urandom_range(7));
      bus.commit_data = $urandom;
      bus.rename_we = $urandom_range(1);
      bus.rename_name = ($urandom_range(3) == 0) ? 5'(cn) : 5'($urandom_range(REGS - 1));
      bus.rename_entry = 3'($urandom_range(7));
      bus.flush = ($urandom_range(24) == 0);
      bus.rd_re = 2'($urandom_range(3));
      bus.rd_name = {($urandom_range(2) == 0) ? 5'(cn) : 5'($urandom_range(REGS - 1)),
                     ($urandom_range(1) == 0) ? 5'(cn) : 5'($urandom_range(REGS - 1))};
      cycle(1);
    end
    rst = 0;
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
